issue_ctrl: RTL and testbench

In-order issue controller that sits in front of `decode` and drives its `start`/`inst` inputs. Buffers incoming 32-bit instructions in a small FIFO and presents them one per cycle. Inserts bubbles when the head instruction reads a register that an in-flight instruction will write, because `decode` delivers `rd` three cycles after the read. Provides run/drain sequencing and a stall counter for performance visibility.

---
 rtl/rv_pkg.sv | 47 ++++
 rtl/inst_fifo.sv | 57 +++++
 rtl/issue_ctrl.sv | 134 +++++++++++++
 tb/tb_issue_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 encoding constants and issue-controller state type.
// The opcode constants are also consumed by decode so both sides agree on the encoding.
package rv_pkg;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_SB = 7'b1100011;
  localparam logic [6:0] OPC_UJ = 7'b1101111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic is_writer(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_UJ: is_writer = 1'b1;
      default:              is_writer = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_S, OPC_SB: uses_rs1 = 1'b1;
      default:                     uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_S, OPC_SB: uses_rs2 = 1'b1;
      default:              uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction FIFO, DEPTH x WIDTH, with synchronous clear and active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage, pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: buffers instructions, holds the head while it reads a
// register still in flight through decode, and sequences run/drain.
module issue_ctrl
  import rv_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HAZ_WINDOW = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [31:0]                  in_inst,
  output logic                         in_ready,
  input  logic                         run,
  input  logic                         flush,
  output logic                         start,
  output logic [31:0]                  inst,
  output logic                         stall,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  stall_cycles
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_r, next_state_s;
  logic [31:0]   head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s, fifo_empty_s;
  logic          push_s, pop_s, hazard_s, sb_empty_s, issue_state_s, stall_next_s, writer_s, done_s;
  logic [6:0]    head_opc_s;
  logic [4:0]    head_rd_s, head_rs1_s, head_rs2_s;
  logic          sb_valid_r [HAZ_WINDOW];
  logic [4:0]    sb_rd_r    [HAZ_WINDOW];
  logic          start_r, stall_r;
  logic [31:0]   inst_r;
  logic [15:0]   stall_cycles_r;

  assign push_s = in_valid && !fifo_full_s && !flush;

  inst_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .clear (flush),
    .wdata (in_inst),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_opc_s = head_s[OPC_MSB:OPC_LSB];
  assign head_rd_s  = head_s[RD_MSB:RD_LSB];
  assign head_rs1_s = head_s[RS1_MSB:RS1_LSB];
  assign head_rs2_s = head_s[RS2_MSB:RS2_LSB];
  assign writer_s   = is_writer(head_opc_s) && (head_rd_s != 5'd0);

  // Head is blocked if any in-flight write targets one of its used, non-x0 sources.
  always_comb begin
    hazard_s   = 1'b0;
    sb_empty_s = 1'b1;
    for (int i = 0; i < HAZ_WINDOW; i++) begin
      hazard_s = hazard_s | (sb_valid_r[i] &&
                 ((uses_rs1(head_opc_s) && (head_rs1_s != 5'd0) && (sb_rd_r[i] == head_rs1_s)) ||
                  (uses_rs2(head_opc_s) && (head_rs2_s != 5'd0) && (sb_rd_r[i] == head_rs2_s))));
      sb_empty_s = sb_empty_s & !sb_valid_r[i];
    end
  end

  assign issue_state_s = (state_r == ISSUE) || (state_r == DRAIN);
  assign pop_s         = issue_state_s && !fifo_empty_s && !hazard_s && !flush;
  assign stall_next_s  = issue_state_s && !fifo_empty_s && hazard_s && !flush;

  // Next-state and drain-completion decode.
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE:  next_state_s = run ? ISSUE : IDLE;
      ISSUE: next_state_s = run ? ISSUE : DRAIN;
      DRAIN: begin
        if (run) begin
          next_state_s = ISSUE;
        end else if (fifo_empty_s && sb_empty_s) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, scoreboard shift and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      start_r        <= 1'b0;
      inst_r         <= 32'd0;
      stall_r        <= 1'b0;
      stall_cycles_r <= 16'd0;
      for (int i = 0; i < HAZ_WINDOW; i++) begin
        sb_valid_r[i] <= 1'b0;
        sb_rd_r[i]    <= 5'd0;
      end
    end else begin
      state_r <= next_state_s;
      start_r <= pop_s;
      inst_r  <= pop_s ? head_s : 32'd0;
      stall_r <= stall_next_s;
      if (stall_next_s && (stall_cycles_r != 16'hFFFF)) stall_cycles_r <= stall_cycles_r + 16'd1;
      for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
        sb_valid_r[i] <= sb_valid_r[i-1];
        sb_rd_r[i]    <= sb_rd_r[i-1];
      end
      sb_valid_r[0] <= pop_s && writer_s;
      sb_rd_r[0]    <= head_rd_s;
    end
  end

  assign in_ready     = !fifo_full_s;
  assign count        = fifo_count_s;
  assign start        = start_r;
  assign inst         = inst_r;
  assign stall        = stall_r;
  assign busy         = (state_r != IDLE);
  assign done         = done_s;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl: issue timing, RAW bubbles,
// full FIFO, drain/done, flush and reset during a stall.
module tb_issue_ctrl;

  logic        clk, rst_n, in_valid, in_ready, run, flush, start, stall, busy, done;
  logic [31:0] in_inst, inst;
  logic [2:0]  count;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_seen = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int push_cyc = 0;
  int st_cyc[$];
  logic [31:0] st_inst[$];
  logic [31:0] q[5];

  issue_ctrl #(.DEPTH(4), .HAZ_WINDOW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .run(run), .flush(flush), .start(start), .inst(inst), .stall(stall), .busy(busy),
    .done(done), .count(count), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start) begin
      st_cyc.push_back(cyc);
      st_inst.push_back(inst);
    end
    if (stall) stall_seen = stall_seen + 1;
    if (done) begin
      done_seen = done_seen + 1;
      done_cyc  = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] s_op(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i);
    in_valid = 1'b1;
    in_inst  = i;
    tick();
    push_cyc = cyc;
    in_valid = 1'b0;
    in_inst  = 32'd0;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_inst.delete();
    stall_seen = 0;
    done_seen  = 0;
  endtask

  task automatic go_idle();
    run = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; flush = 1'b0; in_inst = 32'd0;
    repeat (2) tick();
    check_val("rst_start", {31'd0, start}, 32'd0);
    check_val("rst_inst", inst, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_count", {29'd0, count}, 32'd0);
    check_val("rst_stallcyc", {16'd0, stall_cycles}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Independent stream: back-to-back issue, 2-cycle latency
    run = 1'b1;
    tick();
    check_val("run_busy", {31'd0, busy}, 32'd1);
    clear_log();
    push(r_op(7'h00, 5'd1, 5'd2, 5'd3));
    push(r_op(7'h00, 5'd4, 5'd5, 5'd6));
    repeat (8) tick();
    check_val("ind_n", st_cyc.size(), 32'd2);
    if (st_cyc.size() == 2) begin
      check_val("ind_lat", st_cyc[0], push_cyc);
      check_val("ind_gap", st_cyc[1] - st_cyc[0], 32'd1);
      check_val("ind_i0", st_inst[0], r_op(7'h00, 5'd1, 5'd2, 5'd3));
      check_val("ind_i1", st_inst[1], r_op(7'h00, 5'd4, 5'd5, 5'd6));
    end
    check_val("ind_stallcyc", {16'd0, stall_cycles}, 32'd0);

    // RAW hazard: 3 bubbles
    clear_log();
    push(r_op(7'h00, 5'd5, 5'd1, 5'd2));
    push(r_op(7'h20, 5'd6, 5'd5, 5'd3));
    repeat (10) tick();
    check_val("raw_n", st_cyc.size(), 32'd2);
    if (st_cyc.size() == 2) check_val("raw_gap", st_cyc[1] - st_cyc[0], 32'd4);
    check_val("raw_stall", stall_seen, 32'd3);
    check_val("raw_stallcyc", {16'd0, stall_cycles}, 32'd3);

    // x0 destination and x0 sources do not stall
    clear_log();
    push(r_op(7'h00, 5'd0, 5'd1, 5'd2));
    push(r_op(7'h00, 5'd3, 5'd0, 5'd0));
    repeat (8) tick();
    check_val("x0_n", st_cyc.size(), 32'd2);
    if (st_cyc.size() == 2) check_val("x0_gap", st_cyc[1] - st_cyc[0], 32'd1);

    // S-type rs2 depends on I-type writer
    clear_log();
    push(i_op(5'd7, 5'd1, 12'd5));
    push(s_op(5'd7, 5'd2, 12'd0));
    repeat (10) tick();
    check_val("st_n", st_cyc.size(), 32'd2);
    if (st_cyc.size() == 2) check_val("st_gap", st_cyc[1] - st_cyc[0], 32'd4);
    check_val("st_stallcyc", {16'd0, stall_cycles}, 32'd6);

    go_idle();
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    // Full FIFO with run low, then issue all four
    clear_log();
    for (int k = 0; k < 5; k++) q[k] = r_op(7'h00, 5'(10 + k), 5'd20, 5'd21);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_inst = q[k];
      tick();
      if (k == 3) begin
        check_val("full_count", {29'd0, count}, 32'd4);
        check_val("full_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    in_valid = 1'b0;
    check_val("full_hold", {29'd0, count}, 32'd4);
    run = 1'b1;
    tick();
    tick();
    check_val("pop1_count", {29'd0, count}, 32'd3);
    check_val("pop1_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) tick();
    check_val("full_n", st_cyc.size(), 32'd4);
    if (st_cyc.size() == 4) begin
      check_val("full_span", st_cyc[3] - st_cyc[0], 32'd3);
      check_val("full_first", st_inst[0], q[0]);
      check_val("full_last", st_inst[3], q[3]);
    end

    go_idle();

    // Drain: two queued, run pulsed once, done after scoreboard empties
    clear_log();
    push(r_op(7'h00, 5'd1, 5'd2, 5'd3));
    push(r_op(7'h00, 5'd4, 5'd5, 5'd6));
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (10) tick();
    check_val("drain_n", st_cyc.size(), 32'd2);
    check_val("drain_done", done_seen, 32'd1);
    if (st_cyc.size() == 2) check_val("drain_done_at", done_cyc - st_cyc[1], 32'd3);
    check_val("drain_busy", {31'd0, busy}, 32'd0);

    // Flush with 3 queued; push in the flush cycle is dropped
    clear_log();
    push(32'h0000_0013);
    push(32'h0000_0093);
    push(32'h0000_0113);
    check_val("fl_pre", {29'd0, count}, 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0193;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0;
    check_val("fl_count", {29'd0, count}, 32'd0);
    run = 1'b1;
    repeat (6) tick();
    check_val("fl_nostart", st_cyc.size(), 32'd0);

    // Reset during a hazard bubble
    push(r_op(7'h00, 5'd5, 5'd1, 5'd2));
    push(r_op(7'h20, 5'd6, 5'd5, 5'd3));
    tick();
    check_val("rs_stall_pre", {31'd0, stall}, 32'd1);
    done_seen = 0;
    rst_n = 1'b0;
    tick();
    check_val("rs_start", {31'd0, start}, 32'd0);
    check_val("rs_inst", inst, 32'd0);
    check_val("rs_stall", {31'd0, stall}, 32'd0);
    check_val("rs_busy", {31'd0, busy}, 32'd0);
    check_val("rs_count", {29'd0, count}, 32'd0);
    check_val("rs_stallcyc", {16'd0, stall_cycles}, 32'd0);
    rst_n = 1'b1;
    run = 1'b0;
    repeat (3) tick();
    check_val("rs_nodone", done_seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
